// File: rtl/unpack_rq_stream.sv
// Streaming unpacker for Rq / Rq0 polynomials: collects LANES coefficients per beat
// into h_mem and, for Rq0, derives the last coefficient so all coefficients sum to 0 mod q.
module unpack_rq_stream #(
    parameter int unsigned N     = 701,
    parameter int unsigned LOGQ  = 13,
    parameter int unsigned LANES = 2
) (
    input  logic                    clk,
    input  logic                    ovr_rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    in_valid,
    input  logic [LANES*LOGQ-1:0]   in_data,
    output logic                    in_ready,
    output logic [N*LOGQ-1:0]       h_mem,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CW  = $clog2(N + LANES + 1);
    localparam int unsigned HW  = N * LOGQ;
    localparam int unsigned HIW = $clog2(HW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LOGQ-1:0] sum_q, sum_d;
    logic [HW-1:0]   h_mem_q, h_mem_d;
    logic            mode_q, mode_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [CW-1:0]   k_c;
    logic [CW-1:0]   idx_c;
    logic [LOGQ-1:0] lane_c;
    logic [HIW-1:0]  base_c;
    logic            beat_c;

    // State and datapath registers; reset discards any partial polynomial
    always_ff @(posedge clk or posedge ovr_rst) begin
        if (ovr_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sum_q      <= '0;
            h_mem_q    <= '0;
            mode_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            h_mem_q    <= h_mem_d;
            mode_q     <= mode_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state, coefficient writes and running sum
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        h_mem_d = h_mem_q;
        mode_d  = mode_q;
        idx_c   = '0;
        lane_c  = '0;
        base_c  = '0;
        k_c     = mode_q ? CW'(N) : CW'(N - 1);
        beat_c  = in_valid && in_ready_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    sum_d   = '0;
                    h_mem_d = '0;
                    mode_d  = mode;
                end
            end
            S_LOAD: begin
                if (beat_c) begin
                    // Lanes past the last collected coefficient are dropped entirely
                    for (int unsigned j = 0; j < LANES; j++) begin
                        idx_c = cnt_q + CW'(j);
                        if (idx_c < k_c) begin
                            lane_c             = LOGQ'(in_data >> (j * LOGQ));
                            base_c             = HIW'(32'(idx_c) * LOGQ);
                            h_mem_d[base_c +: LOGQ] = lane_c;
                            sum_d              = sum_d + lane_c;
                        end
                    end
                    cnt_d = cnt_q + CW'(LANES);
                    if (cnt_d >= k_c) begin
                        state_d = mode_q ? S_DONE : S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                h_mem_d[(N-1)*LOGQ +: LOGQ] = LOGQ'(0) - sum_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_FINAL);
        done_d     = (state_d == S_DONE);
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign h_mem    = h_mem_q;

endmodule
